// File: rtl/pipo_register_pkg.sv
// rtl/pipo_register_pkg.sv - shared constants for the PIPO holding register
package pipo_register_pkg;

   localparam int unsigned PIPO_DEFAULT_WIDTH = 4;

endpackage : pipo_register_pkg

// File: rtl/pipo_register.sv
// rtl/pipo_register.sv - word-wide PIPO register, Q follows D one clock later
module pipo_register
   import pipo_register_pkg::*;
#(
   parameter int unsigned           WIDTH     = PIPO_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
);

   generate
      if (WIDTH < 1) begin : g_bad_width
         $error("pipo_register: WIDTH must be at least 1");
      end
   endgenerate

   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_q;

   // Reset has priority over the word presented on the same edge.
   assign q_d = rst ? RESET_VAL : D;

   always_ff @(posedge clk) begin
      q_q <= q_d;
   end

   assign Q = q_q;

   a_load_latency : assert property (@(posedge clk) !rst |=> (Q == $past(D)));
   a_reset_value  : assert property (@(posedge clk) rst |=> (Q == RESET_VAL));
   a_no_x_out     : assert property (@(posedge clk) (rst || !$isunknown(D)) |=> !$isunknown(Q));

endmodule : pipo_register

// File: tb/tb_pipo_register.sv
// tb/tb_pipo_register.sv - scoreboard bench for pipo_register at WIDTH 4 and 8
`timescale 1ns / 100ps
module tb_pipo_register;

   typedef struct packed {
      logic [3:0] q4;
      logic [7:0] q8;
   } exp_t;

   typedef struct {
      logic       rst;
      logic [3:0] d4;
      logic [7:0] d8;
   } vec_t;

   localparam logic [7:0] RST8 = 8'hA5;
   localparam logic [3:0] RST4 = 4'h0;

   logic       clk;
   logic       rst;
   logic [3:0] d4;
   logic [3:0] q4;
   logic [7:0] d8;
   logic [7:0] q8;

   exp_t       sb_q[$];
   vec_t       vecs[$];
   int         n_checks;
   int         n_pass;
   bit         stim_done;

   pipo_register dut4 (
      .clk (clk),
      .rst (rst),
      .D   (d4),
      .Q   (q4)
   );

   pipo_register #(
      .WIDTH     (8),
      .RESET_VAL (RST8)
   ) dut8 (
      .clk (clk),
      .rst (rst),
      .D   (d8),
      .Q   (q8)
   );

   initial clk = 1'b0;
   always #2 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: after an edge the register holds the reset word if reset was
   // high at that edge, otherwise whatever word sat on D.
   function automatic exp_t model(input vec_t v);
      exp_t e;
      e.q4 = v.rst ? RST4 : v.d4;
      e.q8 = v.rst ? RST8 : v.d8;
      return e;
   endfunction

   function automatic vec_t mk(input logic r, input logic [3:0] a, input logic [7:0] b);
      vec_t v;
      v.rst = r;
      v.d4  = a;
      v.d8  = b;
      return v;
   endfunction

   initial begin
      logic [3:0] walk[8];
      walk = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1110, 4'b1101, 4'b1011, 4'b0111};

      vecs.push_back(mk(1'b0, 4'b1001, 8'h3C));
      vecs.push_back(mk(1'b1, 4'b1111, 8'hFF));
      vecs.push_back(mk(1'b0, 4'b0110, 8'h3C));
      vecs.push_back(mk(1'b0, 4'b0011, 8'h0F));
      vecs.push_back(mk(1'b0, 4'b1100, 8'hF0));
      vecs.push_back(mk(1'b1, 4'b1010, 8'h5A));
      vecs.push_back(mk(1'b0, 4'b1010, 8'h5A));
      for (int i = 0; i < 8; i++) begin
         vecs.push_back(mk(1'b0, walk[i], 8'(1 << i)));
      end
      for (int i = 0; i < 8; i++) begin
         vecs.push_back(mk(1'b0, 4'hF, ~8'(1 << i)));
      end
      vecs.push_back(mk(1'b1, 4'h5, 8'h00));
      for (int i = 0; i < 150; i++) begin
         vecs.push_back(mk(($urandom_range(0, 7) == 0), 4'($urandom), 8'($urandom)));
      end

      n_checks  = 0;
      n_pass    = 0;
      stim_done = 1'b0;

      foreach (vecs[i]) begin
         if (i != 0) begin
            @(negedge clk);
            // Junk on D and a possible reset glitch between edges must not reach Q.
            d4  = 4'($urandom);
            d8  = 8'($urandom);
            rst = ($urandom_range(0, 1) == 1);
            #1;
         end
         rst = vecs[i].rst;
         d4  = vecs[i].d4;
         d8  = vecs[i].d8;
         sb_q.push_back(model(vecs[i]));
      end
      stim_done = 1'b1;
   end

   initial begin : monitor
      exp_t cur;
      bit   have_cur;
      int   budget;
      have_cur = 1'b0;
      budget   = 0;
      fork
         forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
               cur      = sb_q.pop_front();
               have_cur = 1'b1;
               check("q4_after_edge", {4'h0, q4}, {4'h0, cur.q4});
               check("q8_after_edge", q8, cur.q8);
               check("q4_lsb", {7'h0, q4[0]}, {7'h0, cur.q4[0]});
            end
         end
         forever begin
            @(negedge clk);
            #0.5;
            if (have_cur) begin
               check("q4_stable_midcycle", {4'h0, q4}, {4'h0, cur.q4});
               check("q8_stable_midcycle", q8, cur.q8);
            end
         end
      join_none

      while (!(stim_done && sb_q.size() == 0) && budget < 2000) begin
         @(posedge clk);
         budget++;
      end
      @(negedge clk);
      #1;
      if (sb_q.size() != 0 || !stim_done) begin
         n_checks++;
         $display("FAIL drain_timeout: %0d entries left, expected 0", sb_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_pipo_register
